// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART transmitter.
// Optional parity support is selected by the SPART_TX_PARITY_EN macro.
package spart_pkg;

  localparam int   FRAME_DATA_BITS = 8;
  localparam int   BIT_CNT_W       = $clog2(FRAME_DATA_BITS);
  localparam logic IDLE_LEVEL      = 1'b1;
  localparam logic START_LEVEL     = 1'b0;

`ifdef SPART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} spart_state_e;

  function automatic logic even_parity(input logic [FRAME_DATA_BITS-1:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} spart_state_e;
`endif

endpackage

// File: rtl/spart_tx_if.sv
// Host-side handshake and serial line of the SPART transmitter.
// The host (master) drives the baud tick and requests; the transmitter (slave) drives txd/tbr.
interface spart_tx_if;
  import spart_pkg::*;

  logic                       enable;
  logic                       tx_start;
  logic [FRAME_DATA_BITS-1:0] tx_data;
  logic                       txd;
  logic                       tbr;

  modport master (output enable, tx_start, tx_data, input  txd, tbr);
  modport slave  (input  enable, tx_start, tx_data, output txd, tbr);
endinterface

// File: rtl/spart_bit_timer.sv
// Oversample tick counter; bit_done marks the last enable tick of a serial bit period.
// clear holds the counter at zero so a tick coinciding with frame load is not counted.
module spart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic bit_done
);

  localparam int              TICK_W  = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_TC = TICK_W'(OVERSAMPLE - 1);

  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_at_tc;

  assign w_at_tc = (r_tick_cnt == TICK_TC);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_tick_cnt <= '0;
    end else if (enable) begin
      r_tick_cnt <= w_at_tc ? '0 : r_tick_cnt + 1'b1;
    end
  end

  assign bit_done = enable && !clear && w_at_tc;

endmodule

// File: rtl/spart_tx.sv
// SPART serial transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Parity state and logic exist only when SPART_TX_PARITY_EN is defined.
module spart_tx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  spart_tx_if.slave  bus
);

  spart_state_e               r_state;
  spart_state_e               w_state_next;
  logic [FRAME_DATA_BITS-1:0] r_shift;
  logic [BIT_CNT_W-1:0]       r_bit_cnt;
  logic                       r_txd;
  logic                       w_txd_next;
  logic                       w_tbr;
  logic                       w_accept;
  logic                       w_bit_done;
  logic                       w_last_bit;
`ifdef SPART_TX_PARITY_EN
  logic                       r_parity;
`endif

  assign w_accept   = bus.tx_start && (r_state == IDLE);
  assign w_last_bit = (r_bit_cnt == BIT_CNT_W'(FRAME_DATA_BITS - 1));

  // Counter is held clear throughout IDLE, including the cycle a frame is loaded.
  spart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .enable   (bus.enable),
    .clear    (w_tbr),
    .bit_done (w_bit_done)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:   if (bus.tx_start) w_state_next = START;
      START:  if (w_bit_done)   w_state_next = DATA;
`ifdef SPART_TX_PARITY_EN
      DATA:   if (w_bit_done && w_last_bit) w_state_next = PARITY;
      PARITY: if (w_bit_done)   w_state_next = STOP;
`else
      DATA:   if (w_bit_done && w_last_bit) w_state_next = STOP;
`endif
      STOP:   if (w_bit_done)   w_state_next = IDLE;
      default:                  w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_tbr      = 1'b0;
    w_txd_next = IDLE_LEVEL;
    case (r_state)
      IDLE:   w_tbr      = 1'b1;
      START:  w_txd_next = START_LEVEL;
      DATA:   w_txd_next = r_shift[0];
`ifdef SPART_TX_PARITY_EN
      PARITY: w_txd_next = r_parity;
`endif
      default: ;
    endcase
  end

  // Bit counter saturates at the last index so it never wraps inside a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
`ifdef SPART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_shift   <= bus.tx_data;
      r_bit_cnt <= '0;
`ifdef SPART_TX_PARITY_EN
      r_parity  <= even_parity(bus.tx_data);
`endif
    end else if (r_state == DATA && w_bit_done) begin
      r_shift <= {1'b0, r_shift[FRAME_DATA_BITS-1:1]};
      if (!w_last_bit) r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_txd <= IDLE_LEVEL;
    else     r_txd <= w_txd_next;
  end

  assign bus.txd = r_txd;
  assign bus.tbr = w_tbr;

endmodule

// File: tb/tb_spart_tx.sv
// Scoreboard bench for spart_tx: a tick-level model predicts accepted bytes and busy time,
// a line monitor decodes frames off txd. Honours SPART_TX_PARITY_EN for frame length/parity.
module tb_spart_tx;
  import spart_pkg::*;

  localparam int OS = 16;
`ifdef SPART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  spart_tx_if bus ();

  spart_tx #(.OVERSAMPLE(OS)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0)      return START_LEVEL;
    if (b <= 8)      return d[b-1];
    if (b == NB - 1) return IDLE_LEVEL;
    return logic'($countones(d) % 2);
  endfunction

  // Reference model: a frame lasts NB*OS enable ticks counted after the accepting edge.
  logic [7:0] exp_q[$];
  logic       m_busy = 1'b0;
  int         m_rem  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_rem  <= 0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (bus.tx_start) begin
        m_busy <= 1'b1;
        m_rem  <= OS * NB;
        exp_q.push_back(bus.tx_data);
      end
    end else if (bus.enable) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) m_busy <= 1'b0;
    end
  end

  // txd lags the frame by one clk, so the line sees each tick one edge later.
  logic en_q1 = 1'b0, en_q2 = 1'b0, rst_q1 = 1'b1;
  always @(posedge clk) begin
    en_q1  <= bus.enable;
    en_q2  <= en_q1;
    rst_q1 <= rst;
  end

  bit   chk_en = 1'b0;
  bit   m_act  = 1'b0;
  int   m_bit  = 0;
  int   m_cnt  = 0;
  logic m_lv[NB];

  task automatic check_frame();
    logic [7:0] got, exp;
    for (int i = 0; i < 8; i++) got[i] = m_lv[i+1];
    chk("frame_expected", {31'b0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      chk("frame_data", {24'b0, got}, {24'b0, exp});
      chk("frame_stop", {31'b0, m_lv[NB-1]}, {31'b0, IDLE_LEVEL});
`ifdef SPART_TX_PARITY_EN
      chk("frame_parity", {31'b0, m_lv[9]}, 32'($countones(exp) % 2));
`endif
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tbr_vs_model", {31'b0, bus.tbr}, {31'b0, !m_busy});
      if (!m_busy) chk("idle_line", {31'b0, bus.txd}, {31'b0, IDLE_LEVEL});
    end
    if (rst_q1) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (bus.txd === 1'b0) begin
        m_act = 1'b1; m_bit = 0; m_cnt = 0; m_lv[0] = 1'b0;
      end
    end else begin
      if (en_q2) m_cnt++;
      if (m_cnt == OS) begin
        m_cnt = 0;
        m_bit++;
        if (m_bit == NB) begin
          check_frame();
          m_act = 1'b0;
        end else begin
          m_lv[m_bit] = bus.txd;
        end
      end else begin
        chk("bit_stable", {31'b0, bus.txd}, {31'b0, m_lv[m_bit]});
      end
    end
  end

  // Stimulus: called at a negedge, drives one clk cycle of inputs, returns at the next negedge.
  int en_period = 4;
  int ph = 0;

  task automatic cyc(input logic st, input logic [7:0] d, input logic r);
    bus.enable   = (ph == 0);
    ph           = (ph + 1) % en_period;
    bus.tx_start = st;
    bus.tx_data  = d;
    rst          = r;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      cyc(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("idle_timeout", {31'b0, m_busy}, 32'd0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom), 1'b0);
  endtask

  initial begin
    logic       samp[NB*OS*4];
    logic [7:0] d55;
    int         low_cnt;
    int         n;
    bus.enable = 1'b0; bus.tx_start = 1'b0; bus.tx_data = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_txd", {31'b0, bus.txd}, 32'd1);
    chk("reset_tbr", {31'b0, bus.tbr}, 32'd1);
    chk_en = 1'b1;
    gap(3);

    // 0x55 with enable every 4 clks, request coinciding with an enable tick
    en_period = 4; ph = 0; d55 = 8'h55;
    cyc(1'b1, d55, 1'b0);
    low_cnt = (bus.tbr === 1'b0) ? 1 : 0;
    for (int k = 0; k < NB*OS*4; k++) begin
      cyc(1'b0, 8'h00, 1'b0);
      samp[k] = bus.txd;
      if (bus.tbr === 1'b0) low_cnt++;
    end
    for (int b = 0; b < NB; b++) begin
      n = 0;
      for (int k = b*OS*4; k < (b+1)*OS*4; k++) if (samp[k] !== frame_bit(d55, b)) n++;
      chk("x55_bit_samples_wrong", n, 0);
    end
    chk("x55_tbr_low_clks", low_cnt, NB*OS*4);
    chk("x55_tbr_after", {31'b0, bus.tbr}, 32'd1);
    gap(5);

    // request while busy is ignored
    en_period = 2;
    cyc(1'b1, 8'h0F, 1'b0);
    gap(37);
    cyc(1'b1, 8'hA3, 1'b0);
    gap(100);
    cyc(1'b1, 8'hA3, 1'b0);
    wait_idle(5000);
    gap(20);

    // back-to-back: request in the first idle cycle
    en_period = 3;
    cyc(1'b1, 8'h3C, 1'b0);
    wait_idle(5000);
    cyc(1'b1, 8'h81, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("b2b_start_bit", {31'b0, bus.txd}, {31'b0, START_LEVEL});
    wait_idle(5000);
    gap(4);

    // reset in the middle of data bit 3 of 0xFF
    cyc(1'b1, 8'hFF, 1'b0);
    n = 0;
    while (m_rem > OS*NB - 4*OS - 5 && n < 5000) begin
      cyc(1'b0, 8'h00, 1'b0);
      n++;
    end
    cyc(1'b0, 8'h00, 1'b1);
    chk("rst_mid_txd", {31'b0, bus.txd}, 32'd1);
    chk("rst_mid_tbr", {31'b0, bus.tbr}, 32'd1);
    gap(300);

    // parity-relevant bytes
    en_period = 1; ph = 0;
    cyc(1'b1, 8'h07, 1'b0);
    wait_idle(5000);
    cyc(1'b1, 8'h03, 1'b0);
    wait_idle(5000);
    gap(3);

    // randomized traffic, enable rates, stray requests and occasional resets
    for (int it = 0; it < 40; it++) begin
      en_period = $urandom_range(1, 5);
      ph = ph % en_period;
      for (int c = 0; c < 400; c++)
        cyc(($urandom_range(0, 15) == 0), 8'($urandom), ($urandom_range(0, 999) == 0));
    end

    wait_idle(5000);
    gap(4);
    chk("queue_drained", exp_q.size(), 0);
    chk("monitor_idle", {31'b0, m_act}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spart_tx.md
SPART_TX -- requirements
Module: spart_tx

Interface
- REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning the number of enable ticks per serial bit period (legal range 2..64).
- REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
- REQ-003 SHALL have port rst, input, 1, meaning the reset, which is synchronous and active-high.
- REQ-004 SHALL have port enable, input, 1, meaning the baud tick from the baud generator, asserted for one clk cycle per oversample period.
- REQ-005 SHALL have port tx_start, input, 1, meaning a single-cycle request to transmit tx_data.
- REQ-006 SHALL have port tx_data, input, 8, meaning the byte to send, sampled only when a request is accepted.
- REQ-007 SHALL have port txd, output, 1, meaning the serial line (idle high).
- REQ-008 SHALL have port tbr, output, 1, meaning transmit buffer ready (high only when no frame is in progress).

Function
- REQ-009 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY exists only per REQ-024.
- REQ-010 SHALL drive tbr=1 exactly while in IDLE, else 0.
- REQ-011 SHALL accept tx_start only when tbr=1: latch tx_data into an 8-bit shift register, clear the tick and bit counters, enter START.
- REQ-012 SHALL ignore tx_start while tbr=0: no effect on the frame, the data or the counters.
- REQ-013 SHALL register txd; tx_start accepted at edge N gives txd=0 from edge N+1.
- REQ-014 SHALL hold each bit for exactly OVERSAMPLE enable ticks; clk cycles without enable hold all state.
- REQ-015 SHALL send frame order start(0), data bits LSB first, [parity], stop(1).
- REQ-016 SHALL count data bits with a 3-bit counter, leaving DATA after bit index 7 completes; the counter SHALL NOT wrap mid-frame.
- REQ-017 SHALL, on the final tick of STOP, return to IDLE (tbr=1, txd=1) at the next edge; a tx_start in that IDLE cycle is accepted (back-to-back frames, one idle clk gap).
- REQ-018 SHALL, when enable and an accepted tx_start coincide in IDLE, load the frame and not count that tick toward the start bit.
- REQ-019 SHALL use a tick counter of width ceil(log2(OVERSAMPLE)) that wraps to 0 at OVERSAMPLE-1, producing the bit-advance strobe.

Reset
- REQ-020 SHALL, on rst=1 at a clk edge, enter IDLE with txd=1, tbr=1, counters 0 and the shift register 0.
- REQ-021 SHALL, on rst mid-frame, abort the frame with txd=1 on the following edge; no partial bits are resumed.
- REQ-022 SHALL give rst priority over tx_start and enable in the same cycle.

Configuration
- REQ-023 SHALL be controlled by macro SPART_TX_PARITY_EN.
- REQ-024 SHALL, when SPART_TX_PARITY_EN is defined, insert the PARITY state after DATA, sending even parity (XOR of the 8 latched data bits) for OVERSAMPLE ticks; when undefined, go DATA->STOP directly, with no parity logic and no PARITY state encoding.

Structure
- REQ-025 SHALL place the FSM state enum and the constants FRAME_DATA_BITS=8, IDLE_LEVEL=1 and START_LEVEL=0 in shared package spart_pkg.
- REQ-026 SHALL factor the tick counter and bit-advance strobe into sub-module spart_bit_timer (inputs clk, rst, enable, clear; output bit_done).

Verification
- REQ-027 SHALL cover: OVERSAMPLE=16, enable every 4 clks, tx_start with 0x55 -> txd sequence 0,1,0,1,0,1,0,1,0,1 with each bit 64 clks, tbr low for 640 clks, then high.
- REQ-028 SHALL cover: tx_start with 0xA3 while busy with 0x0F -> line shows only 0x0F; tbr returns to 1 after the stop bit with no second frame.
- REQ-029 SHALL cover: tx_start 0x81 in the first cycle tbr=1 after a frame -> new start bit begins at the next edge, frames 0x81 correct.
- REQ-030 SHALL cover: rst asserted during data bit 3 of 0xFF -> txd=1 and tbr=1 at the next edge, no further activity until a new tx_start.
- REQ-031 SHALL cover: with SPART_TX_PARITY_EN, data 0x07 -> parity bit 1; data 0x03 -> parity bit 0; without the macro, the stop bit follows bit 7 directly.
- REQ-032 SHALL cover: tx_start coinciding with enable -> start bit lasts the full 16 ticks, not 15.
